// File: rtl/sal_ref_ctrl_if.sv
// Refresh-controller handshake bundle: bank drain status, bank stall request,
// scheduler command channel and status flags.
interface sal_ref_ctrl_if #(
  parameter int unsigned BK_CNT       = 8,
  parameter int unsigned MAX_POSTPONE = 8
);
  localparam int unsigned DW = $clog2(MAX_POSTPONE + 1);

  logic              ref_en;
  logic [BK_CNT-1:0] bk_ready;
  logic              ref_req;
  logic              cmd_valid;
  logic [1:0]        cmd_code;
  logic              cmd_ready;
  logic              ref_busy;
  logic              ref_urgent;
  logic [DW-1:0]     debt;
  logic              ovf_err;

  modport slave (
    input  ref_en, bk_ready, cmd_ready,
    output ref_req, cmd_valid, cmd_code, ref_busy, ref_urgent, debt, ovf_err
  );

  modport master (
    output ref_en, bk_ready, cmd_ready,
    input  ref_req, cmd_valid, cmd_code, ref_busy, ref_urgent, debt, ovf_err
  );
endinterface

// File: rtl/sal_ref_ctrl.sv
// DDR2 auto-refresh controller: tREFI tick generation, postponed-refresh debt
// tracking, bank quiesce, then PREA + REF issue on the scheduler port.
module sal_ref_ctrl #(
  parameter int unsigned BK_CNT       = 8,
  parameter int unsigned TREFI        = 780,
  parameter int unsigned TRP          = 3,
  parameter int unsigned TRFC         = 13,
  parameter int unsigned MAX_POSTPONE = 8
) (
  input logic           clk,
  input logic           rst,
  sal_ref_ctrl_if.slave bus
);

  localparam int unsigned DW   = $clog2(MAX_POSTPONE + 1);
  localparam int unsigned CW   = $clog2(TREFI);
  localparam int unsigned WMAX = (TRP > TRFC) ? TRP : TRFC;
  localparam int unsigned WW   = $clog2(WMAX + 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StDrain    = 3'd1;
  localparam logic [2:0] StPrea     = 3'd2;
  localparam logic [2:0] StTrpWait  = 3'd3;
  localparam logic [2:0] StRef      = 3'd4;
  localparam logic [2:0] StTrfcWait = 3'd5;

  localparam logic [1:0] CmdNop  = 2'd0;
  localparam logic [1:0] CmdPrea = 2'd1;
  localparam logic [1:0] CmdRef  = 2'd2;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [DW-1:0]     debt_q, debt_d;
  logic              ovf_q, ovf_d;
  logic              urgent_q;
  logic              ref_req_q, ref_req_d;
  logic              busy_q, busy_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [1:0]        cmd_code_q, cmd_code_d;
  logic [BK_CNT-1:0] bk_all;
  logic              tick;
  logic              ref_hs;
  logic              debt_nz;

  assign bk_all  = bus.bk_ready;
  assign tick    = bus.ref_en && (cnt_q == '0);
  assign ref_hs  = cmd_valid_q && bus.cmd_ready && (cmd_code_q == CmdRef);
  assign debt_nz = (debt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (bus.ref_en) begin
      cnt_d = tick ? CW'(TREFI - 1) : cnt_q - CW'(1);
    end
  end

  // A tick and a REF handshake in the same cycle cancel; saturation flags overflow.
  always_comb begin
    debt_d = debt_q;
    ovf_d  = ovf_q;
    if (tick && !ref_hs) begin
      if (debt_q == DW'(MAX_POSTPONE)) begin
        ovf_d = 1'b1;
      end else begin
        debt_d = debt_q + DW'(1);
      end
    end else if (ref_hs && !tick && debt_nz) begin
      debt_d = debt_q - DW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      StIdle: begin
        if (debt_nz && bus.ref_en) state_d = StDrain;
      end
      StDrain: begin
        if (&bk_all) state_d = StPrea;
      end
      StPrea: begin
        if (bus.cmd_ready) begin
          state_d = StTrpWait;
          wait_d  = WW'(TRP - 1);
        end
      end
      StTrpWait: begin
        if (wait_q == '0) state_d = StRef;
        else              wait_d  = wait_q - WW'(1);
      end
      StRef: begin
        if (bus.cmd_ready) begin
          state_d = StTrfcWait;
          wait_d  = WW'(TRFC - 1);
        end
      end
      StTrfcWait: begin
        // Banks are still closed, so further owed refreshes skip the PREA.
        if (wait_q == '0) state_d = (debt_nz && bus.ref_en) ? StRef : StIdle;
        else              wait_d  = wait_q - WW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge.
  always_comb begin
    ref_req_d   = (state_d != StIdle);
    busy_d      = (state_d != StIdle);
    cmd_valid_d = (state_d == StPrea) || (state_d == StRef);
    cmd_code_d  = CmdNop;
    if (state_d == StPrea)     cmd_code_d = CmdPrea;
    else if (state_d == StRef) cmd_code_d = CmdRef;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= CW'(TREFI - 1);
      wait_q      <= '0;
      debt_q      <= '0;
      ovf_q       <= 1'b0;
      urgent_q    <= 1'b0;
      ref_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= CmdNop;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      debt_q      <= debt_d;
      ovf_q       <= ovf_d;
      // Derived from the current debt register, so it trails debt by one cycle.
      urgent_q    <= (debt_q >= DW'(MAX_POSTPONE - 1));
      ref_req_q   <= ref_req_d;
      busy_q      <= busy_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
    end
  end

  assign bus.ref_req    = ref_req_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_code   = cmd_code_q;
  assign bus.ref_busy   = busy_q;
  assign bus.ref_urgent = urgent_q;
  assign bus.debt       = debt_q;
  assign bus.ovf_err    = ovf_q;

endmodule

// File: tb/tb_sal_ref_ctrl.sv
// Bench for sal_ref_ctrl: directed scenarios plus random traffic, all checked
// cycle by cycle against a phase/timer reference model of the refresh rules.
module tb_sal_ref_ctrl;
  localparam int unsigned BK    = 8;
  localparam int unsigned TREFI = 20;
  localparam int unsigned TRP   = 2;
  localparam int unsigned TRFC  = 5;
  localparam int unsigned MAXP  = 4;
  localparam int unsigned DW    = $clog2(MAXP + 1);

  localparam int PhIdle = 0, PhDrain = 1, PhPrea = 2, PhTrp = 3, PhRef = 4, PhTrfc = 5;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  sal_ref_ctrl_if #(.BK_CNT(BK), .MAX_POSTPONE(MAXP)) bus ();

  sal_ref_ctrl #(
    .BK_CNT(BK), .TREFI(TREFI), .TRP(TRP), .TRFC(TRFC), .MAX_POSTPONE(MAXP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: refresh bookkeeping in plain integers, waits as cycles remaining.
  int m_cnt, m_debt, m_ph, m_left;
  bit m_ovf, m_urg;
  logic m_tick, m_hs;
  assign m_tick = bus.ref_en && (m_cnt == 0);
  assign m_hs   = (m_ph == PhRef) && bus.cmd_ready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= TREFI - 1; m_debt <= 0; m_ph <= PhIdle; m_left <= 0;
      m_ovf <= 1'b0; m_urg <= 1'b0;
    end else begin
      if (bus.ref_en) m_cnt <= m_tick ? TREFI - 1 : m_cnt - 1;
      if (m_tick && !m_hs && m_debt == MAXP) m_ovf <= 1'b1;
      else m_debt <= m_debt + (m_tick ? 1 : 0) - (m_hs ? 1 : 0);
      m_urg <= (m_debt >= MAXP - 1);
      case (m_ph)
        PhIdle:  if (m_debt > 0 && bus.ref_en) m_ph <= PhDrain;
        PhDrain: if (bus.bk_ready == '1) m_ph <= PhPrea;
        PhPrea:  if (bus.cmd_ready) begin m_ph <= PhTrp; m_left <= TRP; end
        PhTrp:   if (m_left <= 1) m_ph <= PhRef; else m_left <= m_left - 1;
        PhRef:   if (bus.cmd_ready) begin m_ph <= PhTrfc; m_left <= TRFC; end
        PhTrfc: begin
          if (m_left <= 1) m_ph <= (m_debt > 0 && bus.ref_en) ? PhRef : PhIdle;
          else m_left <= m_left - 1;
        end
        default: m_ph <= PhIdle;
      endcase
    end
  end

  logic [9:0] exp_v, act_v;
  assign exp_v = {m_ph != PhIdle, (m_ph == PhPrea) || (m_ph == PhRef),
                  (m_ph == PhPrea) ? 2'd1 : ((m_ph == PhRef) ? 2'd2 : 2'd0),
                  m_ph != PhIdle, m_urg, DW'(m_debt), m_ovf};
  assign act_v = {bus.ref_req, bus.cmd_valid, bus.cmd_code, bus.ref_busy, bus.ref_urgent,
                  bus.debt, bus.ovf_err};

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_phase(input int ph, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (m_ph == ph) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bus.ref_en = 1'b1; bus.bk_ready = '1; bus.cmd_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (act_v !== 10'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=000", act_v);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      total++;
      if (act_v !== exp_v) begin bad++; $display("FAIL basic_model k=%0d got=%h want=%h", k, act_v, exp_v); end
      case (k)
        19: begin total++; if (bus.debt !== 3'd0) begin bad++; $display("FAIL basic_debt19 got=%0d want=0", bus.debt); end end
        20: begin total++; if ({bus.debt, bus.ref_req} !== {3'd1, 1'b0}) begin bad++; $display("FAIL basic_debt20 got=%0d/%b want=1/0", bus.debt, bus.ref_req); end end
        21: begin total++; if ({bus.ref_req, bus.cmd_valid} !== 2'b10) begin bad++; $display("FAIL basic_req21 got=%b want=10", {bus.ref_req, bus.cmd_valid}); end end
        22: begin total++; if ({bus.cmd_valid, bus.cmd_code} !== 3'b101) begin bad++; $display("FAIL basic_prea22 got=%b want=101", {bus.cmd_valid, bus.cmd_code}); end end
        23: begin total++; if (bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL basic_trp23 got=%b want=0", bus.cmd_valid); end end
        25: begin total++; if ({bus.cmd_valid, bus.cmd_code} !== 3'b110) begin bad++; $display("FAIL basic_ref25 got=%b want=110", {bus.cmd_valid, bus.cmd_code}); end end
        26: begin total++; if (bus.debt !== 3'd0) begin bad++; $display("FAIL basic_debt26 got=%0d want=0", bus.debt); end end
        30: begin total++; if (bus.ref_req !== 1'b1) begin bad++; $display("FAIL basic_req30 got=%b want=1", bus.ref_req); end end
        31: begin total++; if (bus.ref_req !== 1'b0) begin bad++; $display("FAIL basic_req31 got=%b want=0", bus.ref_req); end end
        default: ;
      endcase
    end
  endtask

  task automatic test_drain_stall();
    int k_req = -1, vld = 0, prea = 0, refs = 0;
    bus.bk_ready = '0; bus.cmd_ready = 1'b1; bus.ref_en = 1'b1;
    do_reset();
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      total++;
      if (act_v !== exp_v) begin bad++; $display("FAIL drain_model k=%0d got=%h want=%h", k, act_v, exp_v); end
      if (k_req < 0 && bus.ref_req) k_req = k;
      if (k_req >= 0 && k <= k_req + 100 && bus.cmd_valid) vld++;
      if (k_req >= 0 && k == k_req + 99) begin
        total++;
        if ({bus.debt, bus.ovf_err, bus.ref_urgent} !== {3'd4, 2'b11}) begin
          bad++; $display("FAIL drain_sat got=%0d/%b/%b want=4/1/1", bus.debt, bus.ovf_err, bus.ref_urgent);
        end
      end
      if (k_req >= 0 && k == k_req + 100) bus.bk_ready = '1;
      if (k_req >= 0 && k > k_req + 100 && k <= k_req + 130 && bus.cmd_valid) begin
        if (bus.cmd_code == 2'd1) prea++;
        if (bus.cmd_code == 2'd2) refs++;
      end
    end
    total++;
    if (k_req < 0 || vld != 0) begin bad++; $display("FAIL drain_hold got=req%0d/vld%0d want=seen/0", k_req, vld); end
    total++;
    if (prea != 1 || refs < 4) begin bad++; $display("FAIL drain_release got=prea%0d/ref%0d want=1/>=4", prea, refs); end
  endtask

  task automatic test_prea_stall();
    int k0 = -1;
    bus.bk_ready = '1; bus.cmd_ready = 1'b0; bus.ref_en = 1'b1;
    do_reset();
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      total++;
      if (act_v !== exp_v) begin bad++; $display("FAIL prea_model k=%0d got=%h want=%h", k, act_v, exp_v); end
      if (k0 < 0 && bus.cmd_valid) k0 = k;
      if (k0 >= 0 && k <= k0 + 6) begin
        total++;
        if ({bus.cmd_valid, bus.cmd_code} !== 3'b101) begin bad++; $display("FAIL prea_stable k=%0d got=%b want=101", k, {bus.cmd_valid, bus.cmd_code}); end
      end
      if (k0 >= 0 && k == k0 + 6) bus.cmd_ready = 1'b1;
      if (k0 >= 0 && (k == k0 + 7 || k == k0 + 8)) begin
        total++;
        if (bus.cmd_valid !== 1'b0) begin bad++; $display("FAIL prea_trp k=%0d got=%b want=0", k, bus.cmd_valid); end
      end
      if (k0 >= 0 && k == k0 + 9) begin
        total++;
        if ({bus.cmd_valid, bus.cmd_code} !== 3'b110) begin bad++; $display("FAIL prea_ref got=%b want=110", {bus.cmd_valid, bus.cmd_code}); end
      end
    end
    total++;
    if (k0 < 0) begin bad++; $display("FAIL prea_seen got=none want=PREA"); end
  endtask

  task automatic test_tick_coincide();
    bit hit = 1'b0, done = 1'b0;
    bus.bk_ready = '0; bus.cmd_ready = 1'b0; bus.ref_en = 1'b1;
    do_reset();
    for (int k = 1; k <= 200 && !done; k++) begin
      @(negedge clk);
      total++;
      if (act_v !== exp_v) begin bad++; $display("FAIL coin_model k=%0d got=%h want=%h", k, act_v, exp_v); end
      if (hit) begin
        total++; done = 1'b1;
        if ({bus.debt, bus.ovf_err} !== {3'd2, 1'b0}) begin bad++; $display("FAIL coin_debt got=%0d/%b want=2/0", bus.debt, bus.ovf_err); end
      end
      bus.bk_ready = (m_debt >= 2) ? '1 : '0;
      hit = (m_ph == PhRef) && (m_cnt == 0) && (m_debt == 2);
      bus.cmd_ready = (m_ph == PhPrea) || hit;
    end
    total++;
    if (!done) begin bad++; $display("FAIL coin_timeout got=none want=coincidence"); end
    bus.cmd_ready = 1'b1;
  endtask

  task automatic test_ref_en_off();
    bit ok;
    int refs = 0, late_req = 0;
    bus.bk_ready = '1; bus.cmd_ready = 1'b1; bus.ref_en = 1'b1;
    do_reset();
    wait_phase(PhTrp, 100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL enoff_wait got=timeout want=TRP_WAIT"); end
    bus.ref_en = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      total++;
      if (act_v !== exp_v) begin bad++; $display("FAIL enoff_model k=%0d got=%h want=%h", k, act_v, exp_v); end
      if (bus.cmd_valid && bus.cmd_code == 2'd2) refs++;
      if (k > 20 && bus.ref_req) late_req++;
    end
    total++;
    if (refs != 1 || late_req != 0 || bus.debt !== 3'd0) begin
      bad++; $display("FAIL enoff_result got=ref%0d/late%0d/debt%0d want=1/0/0", refs, late_req, bus.debt);
    end
    bus.ref_en = 1'b1;
  endtask

  task automatic test_rst_trfc();
    bit ok;
    int k1 = -1;
    bus.bk_ready = '1; bus.cmd_ready = 1'b1; bus.ref_en = 1'b1;
    do_reset();
    wait_phase(PhTrfc, 100, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rst_wait got=timeout want=TRFC_WAIT"); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (act_v !== 10'd0) begin bad++; $display("FAIL rst_outputs got=%h want=000", act_v); end
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      total++;
      if (act_v !== exp_v) begin bad++; $display("FAIL rst_model k=%0d got=%h want=%h", k, act_v, exp_v); end
      if (k1 < 0 && bus.debt == 3'd1) k1 = k;
    end
    total++;
    if (k1 != 20) begin bad++; $display("FAIL rst_restart got=%0d want=20", k1); end
  endtask

  task automatic test_random();
    bus.bk_ready = '1; bus.cmd_ready = 1'b1; bus.ref_en = 1'b1;
    do_reset();
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk);
      total++;
      if (act_v !== exp_v) begin bad++; $display("FAIL rand_model k=%0d got=%h want=%h", k, act_v, exp_v); end
      bus.bk_ready  = ($urandom_range(0, 3) == 0) ? BK'($urandom) : '1;
      bus.cmd_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 79) == 0) bus.ref_en = ~bus.ref_en;
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1; @(negedge clk); rst = 1'b0;
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; rst = 1'b1;
    bus.ref_en = 1'b0; bus.bk_ready = '0; bus.cmd_ready = 1'b0;
    test_reset();
    test_basic();
    test_drain_stall();
    test_prea_stall();
    test_tick_coincide();
    test_ref_en_off();
    test_rst_trfc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
